// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable raster timing generator with pattern source.
// Three-stage datapath: stage 0 raster counters, stage 1 request/coordinate
// registers, stage 2 aligned sync/video outputs. Optional feature macro
// VGA_FRAME_CNT_EN adds a 16-bit frameCount output and scrolls the
// checkerboard horizontally by one pixel per frame.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   CW         = 11,
  parameter int   CHECK_LOG2 = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [23:0]   solidColor,
  input  logic [23:0]   pixelIn,
  output logic          pixelReq,
  output logic [CW-1:0] reqX,
  output logic [CW-1:0] reqY,
  output logic          hsync,
  output logic          vsync,
  output logic          dataEnable,
  output logic [CW-1:0] pixelX,
  output logic [CW-1:0] pixelY,
  output logic          frameStart,
  output logic          lineStart,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]   frameCount,
`endif
  output logic [23:0]   RGBchannel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

  // Colour bar palette, left to right.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // Source mux; blanking always forces black.
  function automatic logic [23:0] sel_rgb(input logic active, input logic [1:0] m,
                                          input logic [2:0] bar, input logic chk,
                                          input logic [23:0] solid, input logic [23:0] ext);
    if (!active)
      sel_rgb = 24'h000000;
    else begin
      case (m)
        2'd0:    sel_rgb = solid;
        2'd1:    sel_rgb = bar_rgb(bar);
        2'd2:    sel_rgb = chk ? 24'h000000 : 24'hFFFFFF;
        default: sel_rgb = ext;
      endcase
    end
  endfunction

  logic [CW-1:0] h_p0, v_p0;
  logic [1:0]    mode_p0;
  logic          active_p0;
  logic [CW-1:0] chk_x_p0;

  logic          de_p1, frm_p1, line_p1, chk_p1;
  logic [1:0]    mode_p1;
  logic [2:0]    bar_idx_p1;
  logic [CW-1:0] bar_cnt_p1;

  assign active_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);

  // Stage 0: raster counters; source mode only changes on the wrap to (0,0).
  always_ff @(posedge clock) begin
    if (reset) begin
      h_p0    <= '0;
      v_p0    <= '0;
      mode_p0 <= mode;
    end else if (h_p0 == H_LAST) begin
      h_p0 <= '0;
      if (v_p0 == V_LAST) begin
        v_p0    <= '0;
        mode_p0 <= mode;
      end else begin
        v_p0 <= v_p0 + 1'b1;
      end
    end else begin
      h_p0 <= h_p0 + 1'b1;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt_p0;
  assign frameCount = fcnt_p0;
  assign chk_x_p0   = h_p0 + CW'(fcnt_p0);

  // Stage 0: frame counter, advancing together with the raster wrap.
  always_ff @(posedge clock) begin
    if (reset)
      fcnt_p0 <= '0;
    else if ((h_p0 == H_LAST) && (v_p0 == V_LAST))
      fcnt_p0 <= fcnt_p0 + 1'b1;
  end
`else
  assign chk_x_p0 = h_p0;
`endif

  // Stage 1: request, coordinates and line/frame markers (flushed by reset).
  always_ff @(posedge clock) begin
    if (reset) begin
      reqX     <= '0;
      reqY     <= '0;
      pixelReq <= 1'b0;
      de_p1    <= 1'b0;
      frm_p1   <= 1'b0;
      line_p1  <= 1'b0;
    end else begin
      reqX     <= h_p0;
      reqY     <= v_p0;
      pixelReq <= active_p0 && (mode_p0 == 2'd3);
      de_p1    <= active_p0;
      frm_p1   <= (h_p0 == '0) && (v_p0 == '0);
      line_p1  <= (h_p0 == '0);
    end
  end

  // Stage 1: pattern state; bar index steps by counting, last bar absorbs the remainder.
  always_ff @(posedge clock) begin
    mode_p1 <= mode_p0;
    chk_p1  <= chk_x_p0[CHECK_LOG2] ^ v_p0[CHECK_LOG2];
    if (h_p0 == '0) begin
      bar_cnt_p1 <= '0;
      bar_idx_p1 <= '0;
    end else if ((bar_cnt_p1 == BAR_LAST) && (bar_idx_p1 != 3'd7)) begin
      bar_cnt_p1 <= '0;
      bar_idx_p1 <= bar_idx_p1 + 3'd1;
    end else begin
      bar_cnt_p1 <= bar_cnt_p1 + 1'b1;
    end
  end

  // Stage 2: aligned syncs, markers, coordinates and pixel data.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      dataEnable <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
      lineStart  <= 1'b0;
      RGBchannel <= 24'h000000;
    end else begin
      hsync      <= ((reqX >= HS_FIRST) && (reqX <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync      <= ((reqY >= VS_FIRST) && (reqY <= VS_LAST)) ? VS_POL : ~VS_POL;
      dataEnable <= de_p1;
      pixelX     <= reqX;
      pixelY     <= reqY;
      frameStart <= frm_p1;
      lineStart  <= line_p1;
      RGBchannel <= sel_rgb(de_p1, mode_p1, bar_idx_p1, chk_p1, solidColor, pixelIn);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 28x13 raster.
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VF = 1, VSW = 2, VBP = 2;
  localparam int CW = 11, CL = 2;
  localparam int HT = HA + HF + HSW + HBP;
  localparam int VT = VA + VF + VSW + VBP;
  localparam int FT = HT * VT;
`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd1;
  logic [23:0]   solidColor = 24'h123456;
  logic [23:0]   pixelIn;
  logic          pixelReq, hsync, vsync, dataEnable, frameStart, lineStart;
  logic [CW-1:0] reqX, reqY, pixelX, pixelY;
  logic [23:0]   RGBchannel;
  logic [15:0]   fc_got;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frameCount;
  assign fc_got = frameCount;
`else
  assign fc_got = 16'h0;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .CHECK_LOG2(CL)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .solidColor(solidColor),
    .pixelIn(pixelIn), .pixelReq(pixelReq), .reqX(reqX), .reqY(reqY),
    .hsync(hsync), .vsync(vsync), .dataEnable(dataEnable),
    .pixelX(pixelX), .pixelY(pixelY), .frameStart(frameStart),
    .lineStart(lineStart),
`ifdef VGA_FRAME_CNT_EN
    .frameCount(frameCount),
`endif
    .RGBchannel(RGBchannel)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // External source answers the request with {y, x, A5}.
  always_comb pixelIn = pixelReq ? {reqY[7:0], reqX[7:0], 8'hA5} : 24'h0;

  typedef struct {
    int          cyc;
    string       nm;
    logic        de, hs, vs, fs, ls, req;
    logic [10:0] px, py;
    logic [23:0] rgb;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int t, input string nm, input logic de, input logic hs,
                      input logic vs, input logic fs, input logic ls, input logic req,
                      input logic [10:0] px, input logic [10:0] py,
                      input logic [23:0] rgb, input logic [15:0] fc);
    exp_t e;
    e.cyc = t; e.nm = nm; e.de = de; e.hs = hs; e.vs = vs; e.fs = fs; e.ls = ls;
    e.req = req; e.px = px; e.py = py; e.rgb = rgb; e.fc = fc;
    q.push_back(e);
  endtask

  // Expected outputs for raster pixel (x,y) of frame f counted from release at base.
  task automatic pix(input int base, input int f, input int x, input int y,
                     input logic [23:0] rgb, input logic req, input string nm);
    logic de, hs, vs, fs, ls;
    int fc;
    de = (x < HA) && (y < VA);
    hs = !((x >= HA + HF) && (x < HA + HF + HSW));
    vs = !((y >= VA + VF) && (y < VA + VF + VSW));
    fs = (x == 0) && (y == 0);
    ls = (x == 0);
    fc = f + (((y == VT - 1) && (x >= HT - 2)) ? 1 : 0);
    push(base + 2 + f * FT + y * HT + x, nm, de, hs, vs, fs, ls, req,
         11'(x), 11'(y), rgb, 16'(fc));
  endtask

  task automatic rst_chk(input int t, input string nm);
    push(t, nm, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 24'h0, 16'h0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: compare the scoreboard head when its cycle comes up.
  exp_t        m;
  logic [15:0] want_fc;
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      m = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s not sampled: due t=%0d, now t=%0d", m.nm, m.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      m = q.pop_front();
      checks++;
      want_fc = FC_ON ? m.fc : 16'h0;
      if ({dataEnable, hsync, vsync, frameStart, lineStart, pixelReq, pixelX, pixelY, RGBchannel, fc_got}
          !== {m.de, m.hs, m.vs, m.fs, m.ls, m.req, m.px, m.py, m.rgb, want_fc}) begin
        errors++;
        $display("FAIL %s t=%0d got de=%b hs=%b vs=%b fs=%b ls=%b req=%b x=%0d y=%0d rgb=%h fc=%0d expected de=%b hs=%b vs=%b fs=%b ls=%b req=%b x=%0d y=%0d rgb=%h fc=%0d",
                 m.nm, cyc, dataEnable, hsync, vsync, frameStart, lineStart, pixelReq,
                 pixelX, pixelY, RGBchannel, fc_got, m.de, m.hs, m.vs, m.fs, m.ls,
                 m.req, m.px, m.py, m.rgb, want_fc);
      end
    end
  end

  int r, r2;

  initial begin
    mode       = 2'd1;
    solidColor = 24'h123456;
    reset      = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    checks++;
    if (dataEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_de got %b", dataEnable);
    end
    checks++;
    if (hsync !== 1'b1) begin
      errors++;
      $display("FAIL reset_hsync got %b", hsync);
    end
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL reset_vsync got %b", vsync);
    end
    checks++;
    if (pixelReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got %b", pixelReq);
    end
    checks++;
    if (RGBchannel !== 24'h000000) begin
      errors++;
      $display("FAIL reset_rgb got %h", RGBchannel);
    end
    checks++;
    if (frameStart !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs got %b", frameStart);
    end

    r = cyc;
    rst_chk(r, "reset_state");
    reset = 1'b0;
    rst_chk(r + 1, "no_early_de");

    // Frame 0: colour bars, raster timing
    pix(r, 0,  0,  0, 24'hFFFFFF, 1'b0, "bar0_origin");
    pix(r, 0,  1,  0, 24'hFFFFFF, 1'b0, "bar0_end");
    pix(r, 0,  2,  0, 24'hFFFF00, 1'b0, "bar1");
    pix(r, 0,  8,  0, 24'hFF00FF, 1'b0, "bar4");
    pix(r, 0, 13,  0, 24'h0000FF, 1'b0, "bar6");
    pix(r, 0, 14,  0, 24'h000000, 1'b0, "bar7_start");
    pix(r, 0, 19,  0, 24'h000000, 1'b0, "bar7_last_active");
    pix(r, 0, 20,  0, 24'h000000, 1'b0, "hblank_first");
    pix(r, 0, 21,  0, 24'h000000, 1'b0, "hsync_before");
    pix(r, 0, 22,  0, 24'h000000, 1'b0, "hsync_first");
    pix(r, 0, 24,  0, 24'h000000, 1'b0, "hsync_last");
    pix(r, 0, 25,  0, 24'h000000, 1'b0, "hsync_after");
    pix(r, 0,  0,  1, 24'hFFFFFF, 1'b0, "line1_start");
    pix(r, 0,  2,  3, 24'hFFFF00, 1'b0, "bar1_line3");
    pix(r, 0,  2,  6, 24'hFFFF00, 1'b0, "bars_hold_after_mode_change");
    pix(r, 0,  0,  8, 24'h000000, 1'b0, "vblank_line_start");
    pix(r, 0,  0,  9, 24'h000000, 1'b0, "vsync_first");
    pix(r, 0, 27, 10, 24'h000000, 1'b0, "vsync_last");
    pix(r, 0,  0, 11, 24'h000000, 1'b0, "vsync_after");
    pix(r, 0, 26, 12, 24'h000000, 1'b0, "frame0_end");
    // Frame 1: external source
    pix(r, 1,  0,  0, 24'h0000A5, 1'b1, "ext_origin");
    pix(r, 1, 27,  2, 24'h000000, 1'b1, "ext_req_leads_line");
    pix(r, 1,  4,  3, 24'h0304A5, 1'b1, "ext_4_3");
    pix(r, 1,  5,  3, 24'h0305A5, 1'b1, "ext_5_3");
    pix(r, 1, 19,  3, 24'h0313A5, 1'b0, "ext_last_active");
    pix(r, 1, 20,  3, 24'h000000, 1'b0, "ext_blank");
    pix(r, 1, 19,  7, 24'h0713A5, 1'b0, "ext_holds_after_mode_change");
    pix(r, 1, 27, 12, 24'h000000, 1'b0, "frame1_end");
    // Frame 2: solid colour, then mode 2 requested mid-frame
    pix(r, 2,  5,  1, 24'h123456, 1'b0, "solid_first");
    pix(r, 2,  5,  3, 24'hABCDEF, 1'b0, "solid_resampled");
    pix(r, 2,  3,  6, 24'hABCDEF, 1'b0, "solid_no_tear");
    pix(r, 2, 20,  6, 24'h000000, 1'b0, "solid_blank");
    // Frame 3: checkerboard
    pix(r, 3,  0,  0, 24'hFFFFFF, 1'b0, "chk_0_0");
    pix(r, 3,  4,  0, 24'h000000, 1'b0, "chk_4_0");
    pix(r, 3,  0,  4, 24'h000000, 1'b0, "chk_0_4");
    pix(r, 3,  4,  4, 24'hFFFFFF, 1'b0, "chk_4_4");

    wait_cyc(r + 5 * HT);
    mode = 2'd3;
    wait_cyc(r + FT + 4 * HT);
    mode = 2'd0;
    wait_cyc(r + 2 * FT + 2 * HT);
    solidColor = 24'hABCDEF;
    wait_cyc(r + 2 * FT + 4 * HT);
    mode = 2'd2;

    // One-clock reset in the middle of frame 3 at (10,5)
    wait_cyc(r + 3 * FT + 5 * HT + 10);
    reset = 1'b1;
    @(posedge clock);
    #1;
    r2 = cyc;
    rst_chk(r2, "midframe_reset");
    reset = 1'b0;
    rst_chk(r2 + 1, "reset_flush");
    pix(r2, 0, 0, 0, 24'hFFFFFF, 1'b0, "restart_origin");
    pix(r2, 0, 4, 0, 24'h000000, 1'b0, "restart_chk_4_0");
    pix(r2, 1, 0, 0, 24'hFFFFFF, 1'b0, "restart_frame1");

    wait_cyc(r2 + 2 + FT + 6);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
